sub_mem: RTL

SUB_MEM -- requirements
Module: sub_mem

---
 rtl/AHBCommon_pkg.sv | 32 +++
 rtl/ahb_byte_lanes.sv | 32 +++
 rtl/sub_mem.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/AHBCommon_pkg.sv
// AHBCommon_pkg
// Shared AHB-Lite definitions: transfer type, response encoding, the
// subordinate FSM state enum, and a helper that sizes the byte-offset field
// used for lane selection.
package AHBCommon_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } trans_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Width of the in-word byte offset; kept at least 1 so an 8-bit bus
    // still has a legal (unused) field.
    function automatic int lane_bits(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/ahb_byte_lanes.sv
// ahb_byte_lanes
// Turns the byte offset inside a bus word and the transfer size into a
// little-endian byte strobe vector.
// Ports:
//   addr_lo - byte offset of the transfer inside the data word
//   size    - log2 of the transfer size in bytes
//   strobe  - one bit per byte lane, set for every lane the transfer covers
module ahb_byte_lanes
    import AHBCommon_pkg::*;
#(
    parameter int DataWidth = 32
)(
    input  logic [lane_bits(DataWidth)-1:0] addr_lo,
    input  logic [2:0]                      size,
    output logic [DataWidth/8-1:0]          strobe
);

    localparam int NumLanes = DataWidth / 8;

    // A lane is enabled when it falls in [offset, offset + bytes).
    always_comb begin
        int offset;
        int count;
        offset = (NumLanes > 1) ? int'(addr_lo) : 0;
        count  = 1 << size;
        strobe = '0;
        for (int i = 0; i < NumLanes; i++) begin
            strobe[i] = (i >= offset) && (i < offset + count);
        end
    end

endmodule

// File: rtl/sub_mem.sv
// sub_mem
// AHB-Lite memory subordinate with optional wait states and the two-cycle
// ERROR response for out-of-range, misaligned, oversized or injected faults.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   sel, ready, trans     - subordinate select, bus HREADY, transfer type
//   addr, write, size     - address phase: byte address, direction, log2 bytes
//   wData                 - write data (sampled in the final data-phase cycle)
//   errInject             - force ERROR on the address phase sampled this cycle
//   rData, readyOut, resp - read data, HREADYOUT, OKAY/ERROR response
module sub_mem
    import AHBCommon_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int Depth      = 256,
    parameter int WaitStates = 0
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 ready,
    input  logic [1:0]           trans,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 write,
    input  logic [2:0]           size,
    input  logic [DataWidth-1:0] wData,
    input  logic                 errInject,
    output logic [DataWidth-1:0] rData,
    output logic                 readyOut,
    output logic                 resp
);

    localparam int NumLanes = DataWidth / 8;
    localparam int ByteBits = $clog2(NumLanes);
    localparam int LaneBits = lane_bits(DataWidth);
    localparam int IdxWidth = $clog2(Depth);
    localparam int CntWidth = (WaitStates > 0) ? $clog2(WaitStates + 1) : 1;

    state_t                state, state_next;
    logic [CntWidth-1:0]   count, count_next;
    logic                  pend, pend_next;
    logic [IdxWidth-1:0]   word_q;
    logic [LaneBits-1:0]   lane_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [DataWidth-1:0]  rdata_hold;
    logic [DataWidth-1:0]  mem [Depth];
    logic [NumLanes-1:0]   strobe;
    logic [AddrWidth-1:0]  word_idx;
    logic [7:0]            align_mask;
    logic                  addr_err;
    logic                  accept;
    logic                  final_ok;

    ahb_byte_lanes #(.DataWidth(DataWidth)) u_lanes (
        .addr_lo (lane_q),
        .size    (size_q),
        .strobe  (strobe)
    );

    // Address decode and fault classification for the phase on the bus now.
    // Acceptance also needs our own readyOut, so a phase shown during WAIT or
    // ERR1 is ignored even if the manager drives ready high.
    always_comb begin
        word_idx   = addr >> ByteBits;
        align_mask = 8'((9'd1 << size) - 9'd1);
        addr_err   = (word_idx >= AddrWidth'(Depth))
                  || ((addr[7:0] & align_mask) != 8'd0)
                  || (size > 3'(ByteBits))
                  || errInject;
        accept     = sel && ready && readyOut
                  && ((trans_t'(trans) == TRANS_NONSEQ) || (trans_t'(trans) == TRANS_SEQ));
    end

    // pend marks an accepted OKAY transfer whose data phase is still open;
    // the final cycle is IDLE with pend set (readyOut high).
    assign final_ok = (state == ST_IDLE) && pend;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            pend  <= pend_next;
        end
    end

    // Next-state logic. IDLE and ERR2 both drive readyOut high and therefore
    // both may take a pipelined address phase.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_WAIT: begin
                if (count == CntWidth'(1)) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count - CntWidth'(1);
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                state_next = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WaitStates > 0) begin
                        state_next = ST_WAIT;
                        count_next = CntWidth'(WaitStates);
                    end
                end
            end
        endcase

        if (accept && !addr_err) begin
            pend_next = 1'b1;
        end else if (final_ok) begin
            pend_next = 1'b0;
        end else begin
            pend_next = pend;
        end
    end

    // Output logic.
    always_comb begin
        readyOut = (state == ST_IDLE) || (state == ST_ERR2);
        resp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
        rData    = (final_ok && !write_q) ? mem[word_q] : rdata_hold;
    end

    // Address-phase capture and read-data hold. The hold register takes the
    // word at the end of the read's final cycle so rData stays put afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q     <= '0;
            lane_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
            rdata_hold <= '0;
        end else begin
            if (accept) begin
                word_q  <= word_idx[IdxWidth-1:0];
                lane_q  <= addr[LaneBits-1:0];
                write_q <= write;
                size_q  <= size;
            end
            if (final_ok && !write_q) begin
                rdata_hold <= mem[word_q];
            end
        end
    end

    // Memory is never reset; a write commits only at the end of its final
    // OKAY cycle, so a reset during wait states or an errored write leaves it.
    always_ff @(posedge clk) begin
        if (final_ok && write_q) begin
            for (int i = 0; i < NumLanes; i++) begin
                if (strobe[i]) begin
                    mem[word_q][i*8 +: 8] <= wData[i*8 +: 8];
                end
            end
        end
    end

endmodule
